dma_psdp_ram_seg: RTL and testbench
===================================

Name: dma_psdp_ram_seg

Overview:
- Segmented simple-dual-port DMA buffer RAM: one byte-enabled write port and one pipelined read port per segment.
- Sits directly upstream of the PCIe write DMA engine and serves its ram_rd_cmd / ram_rd_resp interface.
- The write port is filled by the host-side or streaming side of the design.
- Each segment is independent. There is no cross-segment ordering.

Parameters:
- SEG_COUNT, 4, number of independent segments (matches 256-bit PCIe DMA: 2*256/128).
- SEG_DATA_WIDTH, 128, data bits per segment.
- SEG_ADDR_WIDTH, 12, word address bits per segment (depth 2**SEG_ADDR_WIDTH).
- SEG_BE_WIDTH, SEG_DATA_WIDTH/8, byte enables per segment.
- PIPELINE, 2, read pipeline depth in register stages (legal 1..4).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ram_wr_cmd_be  in  SEG_COUNT*SEG_BE_WIDTH  per-segment byte enables.
- ram_wr_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment word address.
- ram_wr_cmd_data  in  SEG_COUNT*SEG_DATA_WIDTH  per-segment write data.
- ram_wr_cmd_valid  in  SEG_COUNT  per-segment write valid.
- ram_wr_cmd_ready  out  SEG_COUNT  per-segment write ready.
- ram_wr_done  out  SEG_COUNT  per-segment write completion pulse.
- ram_rd_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment read address.
- ram_rd_cmd_valid  in  SEG_COUNT  per-segment read valid.
- ram_rd_cmd_ready  out  SEG_COUNT  per-segment read ready.
- ram_rd_resp_data  out  SEG_COUNT*SEG_DATA_WIDTH  per-segment read data.
- ram_rd_resp_valid  out  SEG_COUNT  per-segment read data valid.
- ram_rd_resp_ready  in  SEG_COUNT  per-segment read data ready.

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high.
- Reset values:
  - ram_wr_done=0, ram_rd_resp_valid=0, all pipeline valid bits=0.
  - ram_wr_cmd_ready=1 during reset and after it.
  - ram_rd_cmd_ready follows the pipeline equation below (=1 once valid bits are clear).
  - ram_rd_resp_data is don't-care when valid=0.
  - Memory contents are not cleared by reset.
- Segment i uses slice i of every vector port. Segments never interact.
- Write port:
  - ram_wr_cmd_ready is constant 1.
  - On valid, byte k of the word is written iff be[k]=1. be=0 is legal and performs no write, but still completes.
  - ram_wr_done[i] pulses high exactly one cycle after the accept cycle. Back-to-back writes give back-to-back pulses.
- Read pipeline per segment: stages s[0..PIPELINE-1], each with a valid bit and a data register.
  - s[0] loads mem[addr] on a read accept, i.e. the synchronous RAM output register.
  - Later stages copy the previous stage.
  - Output: ram_rd_resp_valid = s[PIPELINE-1].valid; data = s[PIPELINE-1].data.
  - Stage j advances (ready_j) iff ~s[j].valid or ready_{j+1}. The last stage's ready is ram_rd_resp_ready.
  - ram_rd_cmd_ready = ready_0, which is combinational from the valid bits and resp_ready.
  - A stage whose ready_j=0 holds both data and valid unchanged. Data under a stall must not change, including the RAM output register.
  - Latency: with no stall, a command accepted in cycle N gives resp_valid in cycle N+PIPELINE.
  - Throughput: one read per cycle per segment.
  - Capacity: at most PIPELINE reads outstanding. When all stages are valid and resp_ready=0, cmd_ready=0.
  - Responses return in command order per segment.
- Same-cycle read and write to the same address in one segment: read returns the OLD data (read-first). The next read returns the new data.
- Simultaneous reset with a valid command: the command is not accepted and produces no response or done.
- Reset mid-operation: in-flight reads are discarded and no resp_valid appears afterwards. Writes accepted before reset remain in memory.
- Addresses are SEG_ADDR_WIDTH bits, so there is no out-of-range case.

Test Plan:
- Write seg0 addr 0x010 data 0x00112233...EEFF with be=all-ones, then read seg0 addr 0x010 with resp_ready=1. Required: ram_wr_done[0] one cycle after the write accept; resp_valid[0] exactly 2 cycles after the read accept with the same data; other segments idle.
- Fill seg2 addr 0x005 with 0xAA bytes, then write be=0x0001 data=0x55, then read. Required: byte0=0x55, bytes1..15=0xAA.
- Hold resp_ready[1]=0 and issue reads to seg1 addrs 1,2,3 on consecutive cycles. Required: only 2 accepted, then cmd_ready[1]=0 with resp data/valid stable. Release resp_ready: responses emerge for addr1, then addr2, then addr3, with no loss or duplication.
- Same cycle on seg3 addr 0x7FF: write 0x1234 and read. Required: the old value is returned. A following read returns 0x1234.
- Random per-segment streams of 1000 reads and writes with random resp_ready (50%). Required: a scoreboard per segment matches in-order read data, and done count equals write count.
- Assert rst while 2 reads are in flight on seg0. Required: resp_valid=0 the cycle after reset and no stale response later. A post-reset read returns the memory contents written before reset.

Source files
------------

// File: rtl/dma_psdp_ram_seg_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_psdp_ram_seg_if : per-segment write command and read command/response bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface dma_psdp_ram_seg_if #(
    parameter int SEG_COUNT      = 4,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_ADDR_WIDTH = 12,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8
);
    logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   ram_wr_cmd_be;
    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_wr_cmd_addr;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_wr_cmd_data;
    logic [SEG_COUNT-1:0]                ram_wr_cmd_valid;
    logic [SEG_COUNT-1:0]                ram_wr_cmd_ready;
    logic [SEG_COUNT-1:0]                ram_wr_done;
    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr;
    logic [SEG_COUNT-1:0]                ram_rd_cmd_valid;
    logic [SEG_COUNT-1:0]                ram_rd_cmd_ready;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data;
    logic [SEG_COUNT-1:0]                ram_rd_resp_valid;
    logic [SEG_COUNT-1:0]                ram_rd_resp_ready;

    modport master (
        output ram_wr_cmd_be, ram_wr_cmd_addr, ram_wr_cmd_data, ram_wr_cmd_valid,
        input  ram_wr_cmd_ready, ram_wr_done,
        output ram_rd_cmd_addr, ram_rd_cmd_valid,
        input  ram_rd_cmd_ready, ram_rd_resp_data, ram_rd_resp_valid,
        output ram_rd_resp_ready
    );

    modport slave (
        input  ram_wr_cmd_be, ram_wr_cmd_addr, ram_wr_cmd_data, ram_wr_cmd_valid,
        output ram_wr_cmd_ready, ram_wr_done,
        input  ram_rd_cmd_addr, ram_rd_cmd_valid,
        output ram_rd_cmd_ready, ram_rd_resp_data, ram_rd_resp_valid,
        input  ram_rd_resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/dma_psdp_ram_seg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_psdp_ram_seg : segmented simple-dual-port DMA buffer RAM, pipelined reads
// Rev 1.0
// ----------------------------------------------------------------------------
module dma_psdp_ram_seg #(
    parameter int SEG_COUNT      = 4,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_ADDR_WIDTH = 12,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int PIPELINE       = 2
) (
    input wire logic         clk,
    input wire logic         rst,
    dma_psdp_ram_seg_if.slave bus
);

    assign bus.ram_wr_cmd_ready = '1;

    for (genvar i = 0; i < SEG_COUNT; i++) begin : g_seg
        logic [SEG_DATA_WIDTH-1:0] mem [2**SEG_ADDR_WIDTH];
        logic [SEG_DATA_WIDTH-1:0] stage_data [PIPELINE];
        logic [PIPELINE-1:0]       stage_valid;
        logic [PIPELINE-1:0]       stage_ready;
        logic                      wr_en;
        logic                      rd_en;
        logic                      done;
        logic [SEG_ADDR_WIDTH-1:0] wr_addr;
        logic [SEG_ADDR_WIDTH-1:0] rd_addr;
        logic [SEG_BE_WIDTH-1:0]   wr_be;
        logic [SEG_DATA_WIDTH-1:0] wr_data;

        assign wr_addr = bus.ram_wr_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
        assign rd_addr = bus.ram_rd_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
        assign wr_be   = bus.ram_wr_cmd_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH];
        assign wr_data = bus.ram_wr_cmd_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];

        // Commands presented while rst is high are ignored entirely.
        assign wr_en = bus.ram_wr_cmd_valid[i] & ~rst;
        assign rd_en = bus.ram_rd_cmd_valid[i] & stage_ready[0] & ~rst;

        // Closed form of ready_j = ~valid_j | ready_{j+1}, avoiding a chained vector.
        for (genvar j = 0; j < PIPELINE; j++) begin : g_rdy
            assign stage_ready[j] = bus.ram_rd_resp_ready[i] | ~(&stage_valid[PIPELINE-1:j]);
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int b = 0; b < SEG_BE_WIDTH; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                done <= 1'b0;
            end else begin
                done <= bus.ram_wr_cmd_valid[i];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid <= '0;
            end else begin
                if (stage_ready[0]) begin
                    stage_valid[0] <= rd_en;
                end
                for (int j = 1; j < PIPELINE; j++) begin
                    if (stage_ready[j]) begin
                        stage_valid[j] <= stage_valid[j-1];
                    end
                end
            end
        end

        // Stage 0 is the RAM output register; it only loads on an accept, so a stall freezes it.
        always_ff @(posedge clk) begin
            if (rd_en) begin
                stage_data[0] <= mem[rd_addr];
            end
            for (int j = 1; j < PIPELINE; j++) begin
                if (stage_ready[j]) begin
                    stage_data[j] <= stage_data[j-1];
                end
            end
        end

        assign bus.ram_wr_done[i]       = done;
        assign bus.ram_rd_cmd_ready[i]  = stage_ready[0];
        assign bus.ram_rd_resp_valid[i] = stage_valid[PIPELINE-1];
        assign bus.ram_rd_resp_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = stage_data[PIPELINE-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_psdp_ram_seg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dma_psdp_ram_seg : directed and scoreboarded checks of the segmented DMA RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dma_psdp_ram_seg;
    localparam int SC = 4;
    localparam int DW = 128;
    localparam int AW = 12;
    localparam int BW = 16;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_psdp_ram_seg_if #(.SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW), .SEG_BE_WIDTH(BW)) bus ();

    dma_psdp_ram_seg #(
        .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW), .SEG_BE_WIDTH(BW), .PIPELINE(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ram_wr_cmd_be     = '0;
        bus.ram_wr_cmd_addr   = '0;
        bus.ram_wr_cmd_data   = '0;
        bus.ram_wr_cmd_valid  = '0;
        bus.ram_rd_cmd_addr   = '0;
        bus.ram_rd_cmd_valid  = '0;
        bus.ram_rd_resp_ready = '1;
    endtask

    task automatic set_wr(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.ram_wr_cmd_valid[s]          = 1'b1;
        bus.ram_wr_cmd_addr[s*AW +: AW]  = a;
        bus.ram_wr_cmd_data[s*DW +: DW]  = d;
        bus.ram_wr_cmd_be[s*BW +: BW]    = be;
    endtask

    task automatic set_rd(input int s, input logic [AW-1:0] a);
        bus.ram_rd_cmd_valid[s]         = 1'b1;
        bus.ram_rd_cmd_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] resp(input int s);
        return bus.ram_rd_resp_data[s*DW +: DW];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        total++; if (bus.ram_wr_done !== 4'b0000) begin bad++; $display("FAIL reset_wr_done: got %b want 0000", bus.ram_wr_done); end
        total++; if (bus.ram_rd_resp_valid !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid: got %b want 0000", bus.ram_rd_resp_valid); end
        total++; if (bus.ram_wr_cmd_ready !== 4'b1111) begin bad++; $display("FAIL reset_wr_ready_in_rst: got %b want 1111", bus.ram_wr_cmd_ready); end
        rst = 1'b0;
        tick();
        total++; if (bus.ram_rd_cmd_ready !== 4'b1111) begin bad++; $display("FAIL reset_rd_cmd_ready: got %b want 1111", bus.ram_rd_cmd_ready); end
        total++; if (bus.ram_wr_cmd_ready !== 4'b1111) begin bad++; $display("FAIL reset_wr_ready: got %b want 1111", bus.ram_wr_cmd_ready); end
    endtask

    task automatic test_write_read;
        logic [DW-1:0] d;
        d = 128'h00112233445566778899AABBCCDDEEFF;
        set_wr(0, 12'h010, d, '1);
        tick();
        bus.ram_wr_cmd_valid = '0;
        total++; if (bus.ram_wr_done !== 4'b0001) begin bad++; $display("FAIL wr_done_pulse: got %b want 0001", bus.ram_wr_done); end
        tick();
        total++; if (bus.ram_wr_done !== 4'b0000) begin bad++; $display("FAIL wr_done_single: got %b want 0000", bus.ram_wr_done); end
        set_rd(0, 12'h010);
        #1;
        total++; if (bus.ram_rd_cmd_ready[0] !== 1'b1) begin bad++; $display("FAIL rd_cmd_ready_idle: got %b want 1", bus.ram_rd_cmd_ready[0]); end
        tick();
        bus.ram_rd_cmd_valid = '0;
        total++; if (bus.ram_rd_resp_valid !== 4'b0000) begin bad++; $display("FAIL latency_early: got %b want 0000", bus.ram_rd_resp_valid); end
        tick();
        total++; if (bus.ram_rd_resp_valid !== 4'b0001) begin bad++; $display("FAIL latency_valid: got %b want 0001", bus.ram_rd_resp_valid); end
        total++; if (resp(0) !== d) begin bad++; $display("FAIL read_data_seg0: got %h want %h", resp(0), d); end
        tick();
        total++; if (bus.ram_rd_resp_valid !== 4'b0000) begin bad++; $display("FAIL resp_single: got %b want 0000", bus.ram_rd_resp_valid); end
    endtask

    task automatic test_byte_enable;
        logic [DW-1:0] want;
        want = {{15{8'hAA}}, 8'h55};
        set_wr(2, 12'h005, {16{8'hAA}}, 16'hFFFF);
        tick();
        set_wr(2, 12'h005, {{15{8'h11}}, 8'h55}, 16'h0001);
        tick();
        bus.ram_wr_cmd_valid = '0;
        set_rd(2, 12'h005);
        tick();
        bus.ram_rd_cmd_valid = '0;
        tick();
        total++; if (bus.ram_rd_resp_valid[2] !== 1'b1 || resp(2) !== want) begin bad++; $display("FAIL byte_enable: valid %b data %h want %h", bus.ram_rd_resp_valid[2], resp(2), want); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d1, d2, d3;
        d1 = {4{32'h1111_0001}};
        d2 = {4{32'h2222_0002}};
        d3 = {4{32'h3333_0003}};
        set_wr(1, 12'h001, d1, '1); tick();
        set_wr(1, 12'h002, d2, '1); tick();
        set_wr(1, 12'h003, d3, '1); tick();
        bus.ram_wr_cmd_valid = '0;
        total++; if (bus.ram_wr_done[1] !== 1'b1) begin bad++; $display("FAIL wr_done_b2b: got %b want 1", bus.ram_wr_done[1]); end
        bus.ram_rd_resp_ready[1] = 1'b0;
        set_rd(1, 12'h001);
        #1;
        total++; if (bus.ram_rd_cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_accept1: got %b want 1", bus.ram_rd_cmd_ready[1]); end
        tick();
        set_rd(1, 12'h002);
        #1;
        total++; if (bus.ram_rd_cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_accept2: got %b want 1", bus.ram_rd_cmd_ready[1]); end
        tick();
        set_rd(1, 12'h003);
        #1;
        total++; if (bus.ram_rd_cmd_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", bus.ram_rd_cmd_ready[1]); end
        repeat (3) tick();
        total++; if (bus.ram_rd_cmd_ready[1] !== 1'b0 || bus.ram_rd_resp_valid[1] !== 1'b1 || resp(1) !== d1) begin
            bad++; $display("FAIL bp_stall_hold: ready %b valid %b data %h want ready 0 valid 1 data %h", bus.ram_rd_cmd_ready[1], bus.ram_rd_resp_valid[1], resp(1), d1);
        end
        bus.ram_rd_resp_ready[1] = 1'b1;
        #1;
        total++; if (bus.ram_rd_cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.ram_rd_cmd_ready[1]); end
        tick();
        bus.ram_rd_cmd_valid = '0;
        total++; if (bus.ram_rd_resp_valid[1] !== 1'b1 || resp(1) !== d2) begin bad++; $display("FAIL bp_resp2: valid %b data %h want %h", bus.ram_rd_resp_valid[1], resp(1), d2); end
        tick();
        total++; if (bus.ram_rd_resp_valid[1] !== 1'b1 || resp(1) !== d3) begin bad++; $display("FAIL bp_resp3: valid %b data %h want %h", bus.ram_rd_resp_valid[1], resp(1), d3); end
        tick();
        total++; if (bus.ram_rd_resp_valid[1] !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", bus.ram_rd_resp_valid[1]); end
    endtask

    task automatic test_read_first;
        logic [DW-1:0] old_d, new_d;
        old_d = {4{32'hCAFE_F00D}};
        new_d = 128'h1234;
        set_wr(3, 12'h7FF, old_d, '1);
        tick();
        set_wr(3, 12'h7FF, new_d, '1);
        set_rd(3, 12'h7FF);
        tick();
        bus.ram_wr_cmd_valid = '0;
        bus.ram_rd_cmd_valid = '0;
        tick();
        total++; if (bus.ram_rd_resp_valid[3] !== 1'b1 || resp(3) !== old_d) begin bad++; $display("FAIL read_first_old: valid %b data %h want %h", bus.ram_rd_resp_valid[3], resp(3), old_d); end
        tick();
        set_rd(3, 12'h7FF);
        tick();
        bus.ram_rd_cmd_valid = '0;
        tick();
        total++; if (bus.ram_rd_resp_valid[3] !== 1'b1 || resp(3) !== new_d) begin bad++; $display("FAIL read_first_new: valid %b data %h want %h", bus.ram_rd_resp_valid[3], resp(3), new_d); end
        tick();
    endtask

    task automatic test_random;
        logic [DW-1:0] model [SC][16];
        logic [DW-1:0] expq  [SC][64];
        int            head  [SC];
        int            cnt   [SC];
        int            wr_cnt[SC];
        int            dn_cnt[SC];
        logic [3:0]    ra, wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] wbe;
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < SC; s++) begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                model[s][a] = wd;
                set_wr(s, 12'h100 + 12'(a), wd, '1);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        for (int s = 0; s < SC; s++) begin
            head[s] = 0; cnt[s] = 0; wr_cnt[s] = 0; dn_cnt[s] = 0;
        end
        for (int cyc = 0; cyc < 1100; cyc++) begin
            for (int s = 0; s < SC; s++) begin
                if (bus.ram_wr_done[s] === 1'b1) dn_cnt[s]++;
            end
            for (int s = 0; s < SC; s++) begin
                bus.ram_wr_cmd_valid[s]  = (cyc < 1000) && ($urandom_range(1) == 1);
                bus.ram_rd_cmd_valid[s]  = (cyc < 1000) && ($urandom_range(1) == 1);
                bus.ram_rd_resp_ready[s] = (cyc >= 1000) || ($urandom_range(1) == 1);
                bus.ram_wr_cmd_addr[s*AW +: AW] = 12'h100 + 12'($urandom_range(15));
                bus.ram_rd_cmd_addr[s*AW +: AW] = 12'h100 + 12'($urandom_range(15));
                bus.ram_wr_cmd_data[s*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                bus.ram_wr_cmd_be[s*BW +: BW]   = 16'($urandom);
            end
            #1;
            for (int s = 0; s < SC; s++) begin
                if (bus.ram_rd_resp_valid[s] === 1'b1 && bus.ram_rd_resp_ready[s] === 1'b1) begin
                    total++;
                    if (cnt[s] == 0) begin
                        bad++; $display("FAIL rand_unexpected_resp seg%0d: got %h want none", s, resp(s));
                    end else begin
                        if (resp(s) !== expq[s][head[s]]) begin
                            bad++; $display("FAIL rand_data seg%0d: got %h want %h", s, resp(s), expq[s][head[s]]);
                        end
                        head[s] = (head[s] + 1) % 64;
                        cnt[s]--;
                    end
                end
                ra = bus.ram_rd_cmd_addr[s*AW +: 4];
                if (bus.ram_rd_cmd_valid[s] === 1'b1 && bus.ram_rd_cmd_ready[s] === 1'b1) begin
                    expq[s][(head[s] + cnt[s]) % 64] = model[s][ra];
                    cnt[s]++;
                end
                if (bus.ram_wr_cmd_valid[s] === 1'b1) begin
                    wa  = bus.ram_wr_cmd_addr[s*AW +: 4];
                    wd  = bus.ram_wr_cmd_data[s*DW +: DW];
                    wbe = bus.ram_wr_cmd_be[s*BW +: BW];
                    for (int b = 0; b < BW; b++) begin
                        if (wbe[b]) model[s][wa][b*8 +: 8] = wd[b*8 +: 8];
                    end
                    wr_cnt[s]++;
                end
            end
            tick();
        end
        idle_inputs();
        for (int s = 0; s < SC; s++) begin
            total++; if (cnt[s] != 0) begin bad++; $display("FAIL rand_outstanding seg%0d: got %0d want 0", s, cnt[s]); end
            total++; if (dn_cnt[s] != wr_cnt[s]) begin bad++; $display("FAIL rand_done_count seg%0d: got %0d want %0d", s, dn_cnt[s], wr_cnt[s]); end
        end
    endtask

    task automatic test_reset_inflight;
        logic [DW-1:0] dr, ds, dz;
        int seen;
        dr = {4{32'hDEAD_0020}};
        ds = {4{32'h5EC1_0030}};
        dz = {4{32'hBAD0_BAD0}};
        set_wr(0, 12'h020, dr, '1);
        set_wr(1, 12'h030, ds, '1);
        tick();
        idle_inputs();
        tick();
        bus.ram_rd_resp_ready[0] = 1'b0;
        set_rd(0, 12'h020); tick();
        set_rd(0, 12'h021); tick();
        bus.ram_rd_cmd_valid = '0;
        rst = 1'b1;
        set_wr(1, 12'h030, dz, '1);
        set_rd(1, 12'h030);
        tick();
        total++; if (bus.ram_rd_resp_valid !== 4'b0000) begin bad++; $display("FAIL rst_flush_valid: got %b want 0000", bus.ram_rd_resp_valid); end
        rst = 1'b0;
        idle_inputs();
        tick();
        total++; if (bus.ram_wr_done[1] !== 1'b0) begin bad++; $display("FAIL rst_cmd_done: got %b want 0", bus.ram_wr_done[1]); end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.ram_rd_resp_valid !== 4'b0000) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_stale_resp: got %0d cycles with valid want 0", seen); end
        set_rd(0, 12'h020);
        set_rd(1, 12'h030);
        tick();
        bus.ram_rd_cmd_valid = '0;
        tick();
        total++; if (bus.ram_rd_resp_valid[0] !== 1'b1 || resp(0) !== dr) begin bad++; $display("FAIL rst_mem_kept: valid %b data %h want %h", bus.ram_rd_resp_valid[0], resp(0), dr); end
        total++; if (bus.ram_rd_resp_valid[1] !== 1'b1 || resp(1) !== ds) begin bad++; $display("FAIL rst_write_ignored: valid %b data %h want %h", bus.ram_rd_resp_valid[1], resp(1), ds); end
        tick();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_read_first();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
